matrix_line_buffer: RTL and testbench

//  Builds the three vertically aligned pixel rows that feed the 3x3 morphology stages
//  (corrode/dilate) of the closing pipeline. Takes a raster pixel stream, one pixel per

---
 rtl/matrix_line_buffer_pkg.sv | 9 +
 rtl/line_ram.sv | 25 ++
 rtl/matrix_line_buffer.sv | 107 ++++++++++
 tb/tb_matrix_line_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_line_buffer_pkg.sv
// Shared constants for the closing-pipeline window stages (line buffer, corrode, dilate).
package matrix_line_buffer_pkg;
  localparam int WIDTH_DEF      = 24;
  localparam int PIC_WIDTH_DEF  = 250;
  localparam int PIC_HEIGHT_DEF = 250;
  localparam int CNT_W          = 11;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/line_ram.sv
// Single-clock simple dual-port line memory with a registered, read-first output.
module line_ram #(
  parameter int DEPTH = 250,
  parameter int WIDTH = 24,
  parameter int AW    = 8
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  // Non-blocking write and read on the same edge give read-first behaviour.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_q <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_q;
endmodule

// File: rtl/matrix_line_buffer.sv
// Raster-to-column converter: emits (row-2, row-1, row) pixel triples one clock after
// each accepted pixel, once two lines of the current frame have been buffered.
module matrix_line_buffer
  import matrix_line_buffer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
  parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3
);
  localparam int AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

  cnt_t r_col_cnt, r_row_cnt, r_row_d;
  cnt_t w_col, w_row, w_col_nxt, w_row_nxt;
  logic w_live;
  logic r_vld_d, r_show;
  logic [AW-1:0] r_col_d;
  logic [WIDTH-1:0] r_dout3, r_hold1, r_hold2;
  logic [WIDTH-1:0] w_ram0_q, w_ram1_q;

  // sof forces the current pixel to (0,0); the counters then continue from (0,1).
  always_comb begin
    w_col     = sof ? '0 : r_col_cnt;
    w_row     = sof ? '0 : r_row_cnt;
    w_col_nxt = w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_col == cnt_t'(PIC_WIDTH - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == cnt_t'(PIC_HEIGHT - 1)) ? '0 : w_row + 1'b1;
    end
  end

  assign w_live = (w_row >= cnt_t'(2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_row_d   <= '0;
      r_vld_d   <= 1'b0;
      r_show    <= 1'b0;
    end else begin
      r_vld_d <= valid_in;
      if (valid_in) begin
        r_col_cnt <= w_col_nxt;
        r_row_cnt <= w_row_nxt;
        r_row_d   <= w_row;
        r_show    <= w_live;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) r_col_d <= w_col[AW-1:0];
  end

  // The RAM output registers keep moving while a frame primes, so the last emitted
  // triple is latched here and shown instead until live rows resume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout3 <= '0;
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else begin
      if (valid_in && w_live) r_dout3 <= din;
      if (r_show) begin
        r_hold1 <= w_ram1_q;
        r_hold2 <= w_ram0_q;
      end
    end
  end

  line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH), .AW(AW)) u_ram0 (
    .i_clk     (clk),
    .i_wr_en   (valid_in),
    .i_wr_addr (w_col[AW-1:0]),
    .i_wr_data (din),
    .i_rd_en   (valid_in),
    .i_rd_addr (w_col[AW-1:0]),
    .o_rd_data (w_ram0_q)
  );

  // Second line is refilled one cycle late from the first RAM's read-out.
  line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH), .AW(AW)) u_ram1 (
    .i_clk     (clk),
    .i_wr_en   (r_vld_d),
    .i_wr_addr (r_col_d),
    .i_wr_data (w_ram0_q),
    .i_rd_en   (valid_in),
    .i_rd_addr (w_col[AW-1:0]),
    .o_rd_data (w_ram1_q)
  );

  assign valid_out = r_vld_d && (r_row_d >= cnt_t'(2));
  assign dout1     = r_show ? w_ram1_q : r_hold1;
  assign dout2     = r_show ? w_ram0_q : r_hold2;
  assign dout3     = r_dout3;
endmodule

// File: tb/tb_matrix_line_buffer.sv
// Scoreboard bench for matrix_line_buffer: small 4x3 instance plus a full 250x250 frame.
module tb_matrix_line_buffer;
  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sof, vin;
  logic [W-1:0] din, d1, d2, d3;
  logic vout;
  logic b_rst_n, b_sof, b_vin;
  logic [W-1:0] b_din, b_d1, b_d2, b_d3;
  logic b_vout;

  matrix_line_buffer #(.WIDTH(W), .PIC_WIDTH(4), .PIC_HEIGHT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(vin), .din(din),
    .valid_out(vout), .dout1(d1), .dout2(d2), .dout3(d3));

  matrix_line_buffer #(.WIDTH(W), .PIC_WIDTH(250), .PIC_HEIGHT(250)) u_big (
    .clk(clk), .rst_n(b_rst_n), .sof(b_sof), .valid_in(b_vin), .din(b_din),
    .valid_out(b_vout), .dout1(b_d1), .dout2(b_d2), .dout3(b_d3));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] e1, e2, e3;
    int           due;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tr = 0, tc = 0;
  bit in_reset = 1'b1;
  logic [W-1:0] p1, p2, p3;
  int b_cnt = 0, br = 2, bc = 0;

  function automatic logic [W-1:0] pix(input int r, input int c);
    return W'(16 * r + c);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    sof = 1'b0;
    repeat (n) tick();
  endtask

  // Drive one pixel at the bench's current (tr,tc); sof restarts the bench position.
  task automatic send(input bit s);
    if (s) begin
      tr = 0;
      tc = 0;
    end
    vin = 1'b1;
    sof = s;
    din = pix(tr, tc);
    if (tr >= 2) q.push_back('{pix(tr - 2, tc), pix(tr - 1, tc), pix(tr, tc), cyc + 1});
    tc++;
    if (tc == 4) begin
      tc = 0;
      tr = (tr == 2) ? 0 : tr + 1;
    end
    tick();
    vin = 1'b0;
    sof = 1'b0;
  endtask

  task automatic frame(input bit s, input int idle_pct);
    for (int i = 0; i < 12; i++) begin
      while ($urandom_range(99) < idle_pct) idle(1);
      send(s && (i == 0));
    end
  endtask

  task automatic drain(input string name);
    idle(3);
    check(name, 96'(q.size()), 96'd0);
    q.delete();
  endtask

  // Small-instance monitor: pops on every valid_out, otherwise douts must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (vout) begin
          if (q.size() == 0) begin
            check("spurious_valid", 96'(vout), 96'd0);
          end else begin
            e = q.pop_front();
            check("dout1", 96'(d1), 96'(e.e1));
            check("dout2", 96'(d2), 96'(e.e2));
            check("dout3", 96'(d3), 96'(e.e3));
            check("latency", 96'(cyc), 96'(e.due));
          end
        end else begin
          check("hold_douts", {24'd0, d1, d2, d3}, {24'd0, p1, p2, p3});
        end
      end
      p1 = d1;
      p2 = d2;
      p3 = d3;
    end
  end

  // Large-instance monitor: golden column model walks rows 2..249.
  initial begin
    forever begin
      @(negedge clk);
      if (b_rst_n && b_vout) begin
        check("big_triple", {24'd0, b_d1, b_d2, b_d3},
              {24'd0, pix(br - 2, bc), pix(br - 1, bc), pix(br, bc)});
        b_cnt++;
        bc++;
        if (bc == 250) begin
          bc = 0;
          br = (br == 249) ? 2 : br + 1;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; b_rst_n = 1'b0;
    sof = 1'b0; vin = 1'b0; din = '0;
    b_sof = 1'b0; b_vin = 1'b0; b_din = '0;
    repeat (3) tick();
    check("reset_valid", 96'(vout), 96'd0);
    check("reset_douts", {24'd0, d1, d2, d3}, 96'd0);
    check("reset_big_valid", 96'(b_vout), 96'd0);
    rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
    in_reset = 1'b0;

    // Test 1: one frame, sof on first pixel
    frame(1'b1, 0);
    drain("t1_drain");

    // Test 2: two frames back-to-back (sof at natural wrap, then none)
    frame(1'b1, 0);
    frame(1'b0, 0);
    drain("t2_drain");

    // Test 3: random idle gaps
    frame(1'b1, 30);
    frame(1'b0, 30);
    drain("t3_drain");

    // Test 4: reset right after pixel (2,1)
    for (int i = 0; i < 10; i++) send(i == 0);
    @(negedge clk);
    #1;
    in_reset = 1'b1;
    rst_n = 1'b0;
    tick();
    check("t4_rst_valid", 96'(vout), 96'd0);
    check("t4_rst_douts", {24'd0, d1, d2, d3}, 96'd0);
    check("t4_queue", 96'(q.size()), 96'd0);
    rst_n = 1'b1;
    tr = 0;
    tc = 0;
    tick();
    in_reset = 1'b0;
    frame(1'b0, 0);
    drain("t4_drain");

    // Test 5: sof mid-frame at what would be pixel (1,2)
    for (int i = 0; i < 6; i++) send(1'b0);
    send(1'b1);
    for (int i = 0; i < 11; i++) send(1'b0);
    drain("t5_drain");

    // Test 6: full 250x250 frame on the large instance
    for (int r = 0; r < 250; r++) begin
      for (int c = 0; c < 250; c++) begin
        b_vin = 1'b1;
        b_sof = (r == 0 && c == 0);
        b_din = pix(r, c);
        tick();
      end
    end
    b_vin = 1'b0;
    b_sof = 1'b0;
    repeat (3) tick();
    check("t6_pulse_count", 96'(b_cnt), 96'(248 * 250));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
